pe_namespace_loader: RTL and testbench

Parametrised successor to the per-PE memory interface. It assembles multi-beat words from the PE memory column into full dataLen words and commits them to the data, weight or meta namespaces, each with its own wrapping write pointer. It adds a serialising weight read-back path with a ready/valid handshake, detection of a namespace switch mid-word, and programmable beat ordering. One instance sits between each PE and its memory column port.

---
 rtl/pe_namespace_loader.sv | 200 ++++++++++++++++++++
 tb/tb_pe_namespace_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_namespace_loader.sv
// pe_namespace_loader: assembles multi-beat memory-column writes into full
// namespace words (data / weight / meta / inst), and serialises weight words
// back onto the memory column through a ready/valid read-back engine.
module pe_namespace_loader #(
  parameter int peId              = 0,
  parameter int logNumPeMemColumn = 2,
  parameter int logMemNamespaces  = 2,
  parameter int dataLen           = 32,
  parameter int memDataLen        = 16,
  parameter int dataAddrLen       = 5,
  parameter int weightAddrLen     = 5,
  parameter int metaAddrLen       = 2,
  parameter int msbFirst          = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_wrt_valid,
  input  logic [logNumPeMemColumn-1:0] peId_mem_in,
  input  logic [logMemNamespaces-1:0]  mem_data_type,
  input  logic [memDataLen-1:0]        mem_data_input,
  input  logic                         mem_weight_rd_valid,
  output logic                         mem_rd_ready,
  output logic                         mem_rd_data_valid,
  output logic [memDataLen-1:0]        mem_data_output,
  input  logic                         inst_restart,
  input  logic [dataLen-1:0]           pe_namespace_weight_out,
  output logic [weightAddrLen-1:0]     weight_read_back_addr,
  output logic [dataLen-1:0]           pe_namespace_data,
  output logic                         pe_namespace_data_wrt,
  output logic [dataAddrLen-1:0]       data_wrt_addr,
  output logic                         pe_namespace_weight_wrt,
  output logic [weightAddrLen-1:0]     weight_wrt_addr,
  output logic                         pe_namespace_meta_wrt,
  output logic [metaAddrLen-1:0]       meta_wrt_addr,
  output logic                         pe_namespace_wrt_done,
  output logic                         type_error
);

  localparam int BEATS = (dataLen + memDataLen - 1) / memDataLen;
  localparam int WORDW = BEATS * memDataLen;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [logNumPeMemColumn-1:0] PE_SEL = logNumPeMemColumn'(peId);

  localparam logic [logMemNamespaces-1:0] NS_INST   = logMemNamespaces'(0);
  localparam logic [logMemNamespaces-1:0] NS_DATA   = logMemNamespaces'(1);
  localparam logic [logMemNamespaces-1:0] NS_WEIGHT = logMemNamespaces'(2);
  localparam logic [logMemNamespaces-1:0] NS_META   = logMemNamespaces'(3);

  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_SEND} rd_state_t;

  // ---------------- write assembler ----------------
  logic                        accept;
  logic                        new_word;
  logic                        switch_err;
  logic [CW-1:0]               beat_cnt;
  logic [CW-1:0]               idx;
  logic [CW-1:0]               slot;
  logic                        last_beat;
  logic [logMemNamespaces-1:0] ns_lat;
  logic [logMemNamespaces-1:0] ns_next;
  logic [WORDW-1:0]            word;
  logic [WORDW-1:0]            word_next;

  assign accept     = mem_wrt_valid && (peId_mem_in == PE_SEL);
  // A type change on a non-first beat abandons the partial word and restarts
  // assembly with this beat as beat 0.
  assign new_word   = (beat_cnt == '0) || (mem_data_type != ns_lat);
  assign switch_err = accept && (beat_cnt != '0) && (mem_data_type != ns_lat);
  assign idx        = new_word ? '0 : beat_cnt;
  assign slot       = (msbFirst != 0) ? (LAST - idx) : idx;
  assign last_beat  = (idx == LAST);
  assign ns_next    = new_word ? mem_data_type : ns_lat;

  // Place the incoming beat into its slice of the word under assembly
  always_comb begin
    word_next = new_word ? '0 : word;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (slot == CW'(k)) word_next[k*memDataLen +: memDataLen] = mem_data_input;
    end
  end

  // Beat counting, namespace latch and registered commit strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt                <= '0;
      ns_lat                  <= '0;
      word                    <= '0;
      type_error              <= 1'b0;
      pe_namespace_data       <= '0;
      pe_namespace_data_wrt   <= 1'b0;
      pe_namespace_weight_wrt <= 1'b0;
      pe_namespace_meta_wrt   <= 1'b0;
      pe_namespace_wrt_done   <= 1'b0;
    end else begin
      type_error              <= switch_err;
      pe_namespace_data       <= '0;
      pe_namespace_data_wrt   <= 1'b0;
      pe_namespace_weight_wrt <= 1'b0;
      pe_namespace_meta_wrt   <= 1'b0;
      pe_namespace_wrt_done   <= 1'b0;
      if (accept) begin
        ns_lat <= ns_next;
        if (last_beat) begin
          beat_cnt              <= '0;
          word                  <= '0;
          pe_namespace_wrt_done <= 1'b1;
          if (ns_next != NS_INST) pe_namespace_data <= word_next[dataLen-1:0];
          case (ns_next)
            NS_DATA:   pe_namespace_data_wrt   <= 1'b1;
            NS_WEIGHT: pe_namespace_weight_wrt <= 1'b1;
            NS_META:   pe_namespace_meta_wrt   <= 1'b1;
            default:   ;
          endcase
        end else begin
          beat_cnt <= idx + 1'b1;
          word     <= word_next;
        end
      end
    end
  end

  // Write pointers advance the cycle after their strobe; restart wins on data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_wrt_addr   <= '0;
      weight_wrt_addr <= '0;
      meta_wrt_addr   <= '0;
    end else begin
      if (inst_restart)               data_wrt_addr   <= '0;
      else if (pe_namespace_data_wrt) data_wrt_addr   <= data_wrt_addr + 1'b1;
      if (pe_namespace_weight_wrt)    weight_wrt_addr <= weight_wrt_addr + 1'b1;
      if (pe_namespace_meta_wrt)      meta_wrt_addr   <= meta_wrt_addr + 1'b1;
    end
  end

  // ---------------- weight read-back ----------------
  rd_state_t        rd_state;
  rd_state_t        rd_next;
  logic             rd_req;
  logic [CW-1:0]    rd_cnt;
  logic [WORDW-1:0] rd_shift;

  assign rd_req = mem_weight_rd_valid && (peId_mem_in == PE_SEL);

  // Read-back state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_state <= RD_IDLE;
    else       rd_state <= rd_next;
  end

  // Read-back next state and handshake outputs
  always_comb begin
    rd_next           = rd_state;
    mem_rd_ready      = 1'b0;
    mem_rd_data_valid = 1'b0;
    mem_data_output   = '0;
    case (rd_state)
      RD_IDLE: begin
        mem_rd_ready = 1'b1;
        if (rd_req) rd_next = RD_FETCH;
      end
      RD_FETCH: rd_next = RD_SEND;
      RD_SEND: begin
        mem_rd_data_valid = 1'b1;
        mem_data_output   = (msbFirst != 0) ? rd_shift[WORDW-1 -: memDataLen]
                                            : rd_shift[memDataLen-1:0];
        if (rd_cnt == LAST) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // Capture, shift-out and read pointer advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_shift              <= '0;
      rd_cnt                <= '0;
      weight_read_back_addr <= '0;
    end else begin
      case (rd_state)
        RD_FETCH: begin
          rd_shift <= WORDW'(pe_namespace_weight_out);
          rd_cnt   <= '0;
        end
        RD_SEND: begin
          rd_shift <= (msbFirst != 0) ? (rd_shift << memDataLen) : (rd_shift >> memDataLen);
          if (rd_cnt == LAST) begin
            rd_cnt                <= '0;
            weight_read_back_addr <= weight_read_back_addr + 1'b1;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_namespace_loader.sv
// Bench for pe_namespace_loader: table of write vectors, hand sequences for
// pointer wrap / restart / reset, and a queue scoreboard for read-back beats.
module tb_pe_namespace_loader;

  localparam logic [1:0] NI = 2'd0, ND = 2'd1, NW = 2'd2, NM = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_wrt_valid;
  logic [1:0]  peId_mem_in;
  logic [1:0]  mem_data_type;
  logic [15:0] mem_data_input;
  logic        mem_weight_rd_valid;
  logic        inst_restart;

  // instance with msbFirst=0
  logic        rd_ready, rd_valid;
  logic [15:0] rd_data;
  logic [31:0] wout, ns_data;
  logic [4:0]  raddr, daddr, waddr;
  logic [1:0]  maddr;
  logic        dwrt, wwrt, mwrt, done, terr;

  // instance with msbFirst=1
  logic        m_rd_ready, m_rd_valid;
  logic [15:0] m_rd_data;
  logic [31:0] m_wout, m_ns_data;
  logic [4:0]  m_raddr, m_daddr, m_waddr;
  logic [1:0]  m_maddr;
  logic        m_dwrt, m_wwrt, m_mwrt, m_done, m_terr;

  logic [31:0] wmem0 [32];
  logic [31:0] wmem1 [32];

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  always #5 clk = ~clk;

  // weight namespace models: one-cycle read latency
  always @(posedge clk) begin
    wout   <= wmem0[raddr];
    m_wout <= wmem1[m_raddr];
  end

  pe_namespace_loader #(.peId(1), .msbFirst(0)) dut (
    .clk(clk), .reset(reset), .mem_wrt_valid(mem_wrt_valid), .peId_mem_in(peId_mem_in),
    .mem_data_type(mem_data_type), .mem_data_input(mem_data_input),
    .mem_weight_rd_valid(mem_weight_rd_valid), .mem_rd_ready(rd_ready),
    .mem_rd_data_valid(rd_valid), .mem_data_output(rd_data), .inst_restart(inst_restart),
    .pe_namespace_weight_out(wout), .weight_read_back_addr(raddr),
    .pe_namespace_data(ns_data), .pe_namespace_data_wrt(dwrt), .data_wrt_addr(daddr),
    .pe_namespace_weight_wrt(wwrt), .weight_wrt_addr(waddr),
    .pe_namespace_meta_wrt(mwrt), .meta_wrt_addr(maddr),
    .pe_namespace_wrt_done(done), .type_error(terr));

  pe_namespace_loader #(.peId(1), .msbFirst(1)) dut_m (
    .clk(clk), .reset(reset), .mem_wrt_valid(mem_wrt_valid), .peId_mem_in(peId_mem_in),
    .mem_data_type(mem_data_type), .mem_data_input(mem_data_input),
    .mem_weight_rd_valid(mem_weight_rd_valid), .mem_rd_ready(m_rd_ready),
    .mem_rd_data_valid(m_rd_valid), .mem_data_output(m_rd_data), .inst_restart(inst_restart),
    .pe_namespace_weight_out(m_wout), .weight_read_back_addr(m_raddr),
    .pe_namespace_data(m_ns_data), .pe_namespace_data_wrt(m_dwrt), .data_wrt_addr(m_daddr),
    .pe_namespace_weight_wrt(m_wwrt), .weight_wrt_addr(m_waddr),
    .pe_namespace_meta_wrt(m_mwrt), .meta_wrt_addr(m_maddr),
    .pe_namespace_wrt_done(m_done), .type_error(m_terr));

  typedef struct {
    logic        vld;
    logic [1:0]  pe;
    logic [1:0]  ty;
    logic [15:0] din;
    logic        dw, ww, mw, dn, te;
    logic [31:0] dout;
    logic [4:0]  da, wa;
    logic [1:0]  ma;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic vld, logic [1:0] pe, logic [1:0] ty, logic [15:0] din,
                              logic dw, logic ww, logic mw, logic dn, logic te,
                              logic [31:0] dout, logic [4:0] da, logic [4:0] wa, logic [1:0] ma);
    vec_t v;
    v.vld = vld; v.pe = pe; v.ty = ty; v.din = din;
    v.dw = dw; v.ww = ww; v.mw = mw; v.dn = dn; v.te = te;
    v.dout = dout; v.da = da; v.wa = wa; v.ma = ma;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [1:0] pe, input logic [1:0] ty,
                       input logic [15:0] din);
    mem_wrt_valid  = vld;
    peId_mem_in    = pe;
    mem_data_type  = ty;
    mem_data_input = din;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".dwrt"}, {31'd0, dwrt}, 0);
    chk({tag, ".wwrt"}, {31'd0, wwrt}, 0);
    chk({tag, ".mwrt"}, {31'd0, mwrt}, 0);
    chk({tag, ".done"}, {31'd0, done}, 0);
    chk({tag, ".terr"}, {31'd0, terr}, 0);
    chk({tag, ".data"}, ns_data, 0);
    chk({tag, ".daddr"}, {27'd0, daddr}, 0);
    chk({tag, ".waddr"}, {27'd0, waddr}, 0);
    chk({tag, ".maddr"}, {30'd0, maddr}, 0);
    chk({tag, ".raddr"}, {27'd0, raddr}, 0);
    chk({tag, ".rvalid"}, {31'd0, rd_valid}, 0);
    chk({tag, ".rready"}, {31'd0, rd_ready}, 1);
  endtask

  logic [4:0]  exp_d;
  logic [15:0] b0, b1;
  int          first0, first1;

  initial begin
    for (int i = 0; i < 32; i++) begin
      wmem0[i] = 32'h1000_0000 + i;
      wmem1[i] = 32'h1000_0000 + i;
    end
    wmem0[0] = 32'hCAFE_F00D;
    wmem1[0] = 32'hCAFE_F00D;

    reset = 1'b1;
    mem_weight_rd_valid = 1'b0;
    inst_restart = 1'b0;
    drive(1'b0, 2'd0, NI, 16'h0);
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;

    //       vld pe  ty  din      dw ww mw dn te  dout          da wa ma
    tbl[0]  = mk(1, 1, ND, 16'hBEEF, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0);
    tbl[1]  = mk(1, 1, ND, 16'hDEAD, 1, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0);
    tbl[2]  = mk(0, 1, ND, 16'h0000, 0, 0, 0, 0, 0, 32'h0,        1, 0, 0);
    tbl[3]  = mk(1, 2, ND, 16'hBEEF, 0, 0, 0, 0, 0, 32'h0,        1, 0, 0);
    tbl[4]  = mk(1, 2, ND, 16'hDEAD, 0, 0, 0, 0, 0, 32'h0,        1, 0, 0);
    tbl[5]  = mk(0, 1, ND, 16'h0000, 0, 0, 0, 0, 0, 32'h0,        1, 0, 0);
    tbl[6]  = mk(1, 1, NW, 16'h7777, 0, 0, 0, 0, 0, 32'h0,        1, 0, 0);
    tbl[7]  = mk(1, 1, NM, 16'h1111, 0, 0, 0, 0, 1, 32'h0,        1, 0, 0);
    tbl[8]  = mk(1, 1, NM, 16'h2222, 0, 0, 1, 1, 0, 32'h22221111, 1, 0, 0);
    tbl[9]  = mk(0, 1, NM, 16'h0000, 0, 0, 0, 0, 0, 32'h0,        1, 0, 1);
    tbl[10] = mk(1, 1, NI, 16'h1234, 0, 0, 0, 0, 0, 32'h0,        1, 0, 1);
    tbl[11] = mk(1, 1, NI, 16'h5678, 0, 0, 0, 1, 0, 32'h0,        1, 0, 1);
    tbl[12] = mk(0, 1, NI, 16'h0000, 0, 0, 0, 0, 0, 32'h0,        1, 0, 1);
    tbl[13] = mk(1, 1, NW, 16'hAAAA, 0, 0, 0, 0, 0, 32'h0,        1, 0, 1);
    tbl[14] = mk(1, 1, NW, 16'h5555, 0, 1, 0, 1, 0, 32'h5555AAAA, 1, 0, 1);
    tbl[15] = mk(0, 1, NW, 16'h0000, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1);
    tbl[16] = mk(0, 1, ND, 16'h9999, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1);
    tbl[17] = mk(0, 1, ND, 16'h9999, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1);
    tbl[18] = mk(1, 1, ND, 16'h0001, 0, 0, 0, 0, 0, 32'h0,        1, 1, 1);
    tbl[19] = mk(1, 1, ND, 16'h0002, 1, 0, 0, 1, 0, 32'h00020001, 1, 1, 1);
    tbl[20] = mk(0, 1, ND, 16'h0000, 0, 0, 0, 0, 0, 32'h0,        2, 1, 1);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].vld, tbl[i].pe, tbl[i].ty, tbl[i].din);
      step();
      chk($sformatf("v%0d.dwrt", i), {31'd0, dwrt}, {31'd0, tbl[i].dw});
      chk($sformatf("v%0d.wwrt", i), {31'd0, wwrt}, {31'd0, tbl[i].ww});
      chk($sformatf("v%0d.mwrt", i), {31'd0, mwrt}, {31'd0, tbl[i].mw});
      chk($sformatf("v%0d.done", i), {31'd0, done}, {31'd0, tbl[i].dn});
      chk($sformatf("v%0d.terr", i), {31'd0, terr}, {31'd0, tbl[i].te});
      chk($sformatf("v%0d.data", i), ns_data, tbl[i].dout);
      chk($sformatf("v%0d.daddr", i), {27'd0, daddr}, {27'd0, tbl[i].da});
      chk($sformatf("v%0d.waddr", i), {27'd0, waddr}, {27'd0, tbl[i].wa});
      chk($sformatf("v%0d.maddr", i), {30'd0, maddr}, {30'd0, tbl[i].ma});
    end

    // data pointer wrap: 31 more words take the pointer 2 .. 31 -> 0 -> 1
    exp_d = 5'd2;
    for (int w = 0; w < 31; w++) begin
      b0 = 16'(w);
      b1 = 16'hA500 | 16'(w);
      drive(1'b1, 2'd1, ND, b0);
      step();
      chk("wrap.b0_dwrt", {31'd0, dwrt}, 0);
      chk("wrap.b0_addr", {27'd0, daddr}, {27'd0, exp_d});
      drive(1'b1, 2'd1, ND, b1);
      step();
      chk("wrap.dwrt", {31'd0, dwrt}, 1);
      chk("wrap.addr", {27'd0, daddr}, {27'd0, exp_d});
      chk("wrap.data", ns_data, {b1, b0});
      exp_d = exp_d + 5'd1;
    end
    drive(1'b0, 2'd1, ND, 16'h0);
    step();
    chk("wrap.final_addr", {27'd0, daddr}, 1);

    // restart coincident with a commit strobe
    drive(1'b1, 2'd1, ND, 16'h0101);
    step();
    drive(1'b1, 2'd1, ND, 16'h0202);
    step();
    chk("rst_commit.dwrt", {31'd0, dwrt}, 1);
    chk("rst_commit.addr", {27'd0, daddr}, 1);
    drive(1'b0, 2'd1, ND, 16'h0);
    inst_restart = 1'b1;
    step();
    inst_restart = 1'b0;
    chk("rst_commit.after", {27'd0, daddr}, 0);

    // read-back on both beat orders; second request lands in RD_SEND
    q0.push_back(16'hF00D); q0.push_back(16'hCAFE);
    q1.push_back(16'hCAFE); q1.push_back(16'hF00D);
    first0 = -1;
    first1 = -1;
    chk("rd.ready_pre", {31'd0, rd_ready}, 1);
    chk("rd_m.ready_pre", {31'd0, m_rd_ready}, 1);
    for (int c = 0; c < 10; c++) begin
      peId_mem_in = 2'd1;
      mem_weight_rd_valid = (c == 0) || (c == 2);
      step();
      if (c == 0) begin
        chk("rd.ready_busy", {31'd0, rd_ready}, 0);
        chk("rd_m.ready_busy", {31'd0, m_rd_ready}, 0);
      end
      if (rd_valid) begin
        if (q0.size() == 0) chk("rd.extra_beat", {31'd0, rd_valid}, 0);
        else begin
          if (first0 < 0) first0 = c;
          chk("rd.beat", {16'd0, rd_data}, {16'd0, q0.pop_front()});
        end
      end
      if (m_rd_valid) begin
        if (q1.size() == 0) chk("rd_m.extra_beat", {31'd0, m_rd_valid}, 0);
        else begin
          if (first1 < 0) first1 = c;
          chk("rd_m.beat", {16'd0, m_rd_data}, {16'd0, q1.pop_front()});
        end
      end
    end
    mem_weight_rd_valid = 1'b0;
    chk("rd.left", q0.size(), 0);
    chk("rd_m.left", q1.size(), 0);
    chk("rd.latency", first0 + 1, 2);
    chk("rd_m.latency", first1 + 1, 2);
    chk("rd.ready_post", {31'd0, rd_ready}, 1);
    chk("rd.addr", {27'd0, raddr}, 1);
    chk("rd_m.addr", {27'd0, m_raddr}, 1);

    // reset in the middle of a word
    drive(1'b1, 2'd1, ND, 16'h0303);
    step();
    drive(1'b1, 2'd1, ND, 16'h0404);
    step();
    drive(1'b1, 2'd1, ND, 16'h1234);
    step();
    chk("mid.daddr_pre", {27'd0, daddr}, 1);
    drive(1'b0, 2'd1, ND, 16'h0);
    reset = 1'b1;
    #2;
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 2'd1, ND, 16'h00BB);
    step();
    chk("post.b0_dwrt", {31'd0, dwrt}, 0);
    chk("post.b0_terr", {31'd0, terr}, 0);
    drive(1'b1, 2'd1, ND, 16'h00AA);
    step();
    chk("post.dwrt", {31'd0, dwrt}, 1);
    chk("post.data", ns_data, 32'h00AA00BB);
    chk("post.addr", {27'd0, daddr}, 0);
    drive(1'b0, 2'd1, ND, 16'h0);
    step();
    chk("post.addr_inc", {27'd0, daddr}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
